// File: rtl/pe_result_drain.sv
// pe_result_drain: captures the four PE results on each rising edge of
// compute_done, queues them as one group, and serializes each group onto a
// valid/ready stream, one result per beat, tagged with its matrix row.
module pe_result_drain #(
    parameter int unsigned OUTPUT_WIDTH  = 64,
    parameter int unsigned NUM_PE        = 4,
    parameter int unsigned MATRIX_ROWS   = 384,
    parameter int unsigned ROW_IDX_WIDTH = 9,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OUTPUT_WIDTH-1:0]  pe1,
    input  logic [OUTPUT_WIDTH-1:0]  pe2,
    input  logic [OUTPUT_WIDTH-1:0]  pe3,
    input  logic [OUTPUT_WIDTH-1:0]  pe4,
    input  logic                     compute_done,
    output logic [OUTPUT_WIDTH-1:0]  out_data,
    output logic [ROW_IDX_WIDTH-1:0] out_row,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     frame_done,
    output logic                     overflow,
    output logic                     busy
);

    localparam int unsigned GROUP_W = NUM_PE * OUTPUT_WIDTH;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned BEAT_W  = $clog2(NUM_PE);

    localparam logic [ROW_IDX_WIDTH-1:0] LAST_ROW  = ROW_IDX_WIDTH'(MATRIX_ROWS - 1);
    localparam logic [BEAT_W-1:0]        LAST_BEAT = BEAT_W'(NUM_PE - 1);
    localparam logic [CNT_W-1:0]         FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Registered state
    state_t                   state_q;
    logic                     cd_q;
    logic [GROUP_W-1:0]       grp_q;
    logic [BEAT_W-1:0]        beat_q;
    logic [ROW_IDX_WIDTH-1:0] row_q;
    logic                     last_q;
    logic                     valid_q;
    logic                     fd_q;
    logic                     ovf_q;
    logic                     busy_q;
    logic [PTR_W-1:0]         wr_q;
    logic [PTR_W-1:0]         rd_q;
    logic [CNT_W-1:0]         cnt_q;

    // Next-state values
    state_t                   state_d;
    logic [GROUP_W-1:0]       grp_d;
    logic [BEAT_W-1:0]        beat_d;
    logic [ROW_IDX_WIDTH-1:0] row_d;
    logic                     last_d;
    logic                     valid_d;
    logic                     fd_d;
    logic                     ovf_d;
    logic                     busy_d;
    logic [PTR_W-1:0]         wr_d;
    logic [PTR_W-1:0]         rd_d;
    logic [CNT_W-1:0]         cnt_d;

    logic                     capture;
    logic                     push;
    logic                     pop;
    logic                     hs;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [GROUP_W-1:0]       cap_word;

    logic [GROUP_W-1:0]       mem [FIFO_DEPTH];

    assign cap_word = {pe4, pe3, pe2, pe1};

    // Group storage; pointers and count live with the rest of the state
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_q] <= cap_word;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cd_q    <= 1'b0;
            grp_q   <= '0;
            beat_q  <= '0;
            row_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            fd_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cd_q    <= compute_done;
            grp_q   <= grp_d;
            beat_q  <= beat_d;
            row_q   <= row_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            fd_q    <= fd_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Serializer next-state, FIFO bookkeeping and registered output values
    always_comb begin
        state_d    = state_q;
        grp_d      = grp_q;
        beat_d     = beat_q;
        row_d      = row_q;
        ovf_d      = ovf_q;
        fd_d       = 1'b0;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        pop        = 1'b0;
        push       = 1'b0;
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == FULL_CNT);
        capture    = compute_done & ~cd_q;
        hs         = valid_q & out_ready;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    grp_d   = mem[rd_q];
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_IDX_WIDTH'(1);
                    fd_d  = last_q;
                    if (beat_q == LAST_BEAT) begin
                        // Back-to-back groups: reload without a bubble
                        if (!fifo_empty) begin
                            pop    = 1'b1;
                            grp_d  = mem[rd_q];
                            beat_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        grp_d  = grp_q >> OUTPUT_WIDTH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop in the same cycle frees the slot a full-FIFO capture needs
        push = capture & (~fifo_full | pop);
        if (capture && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end

        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        if (push) begin
            wr_d = wr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        valid_d = (state_d == SEND);
        last_d  = (state_d == SEND) && (row_d == LAST_ROW);
        busy_d  = (cnt_d != '0) || (state_d != IDLE);
    end

    assign out_data   = grp_q[OUTPUT_WIDTH-1:0];
    assign out_row    = row_q;
    assign out_last   = last_q;
    assign out_valid  = valid_q;
    assign frame_done = fd_q;
    assign overflow   = ovf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Testbench for pe_result_drain: table-driven single-group vectors plus
// hand-written sequences, with a scoreboard checking every handshaked word.
module tb_pe_result_drain;

    localparam int unsigned W    = 64;
    localparam int unsigned RW   = 9;
    localparam int unsigned ROWS = 384;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  pe1, pe2, pe3, pe4;
    logic          compute_done;
    logic [W-1:0]  out_data;
    logic [RW-1:0] out_row;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          frame_done;
    logic          overflow;
    logic          busy;

    pe_result_drain dut (
        .clk          (clk),
        .rst          (rst),
        .pe1          (pe1),
        .pe2          (pe2),
        .pe3          (pe3),
        .pe4          (pe4),
        .compute_done (compute_done),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0]  data;
        logic [RW-1:0] row;
        logic          last;
    } exp_t;

    typedef struct {
        logic [3:0][W-1:0] pe;
        logic              alt;
        int                idle;
    } vec_t;

    exp_t          exp_q[$];
    logic [RW-1:0] exp_row;
    int            nchk = 0;
    int            nfail = 0;
    int            hs_count = 0;
    int            fd_count = 0;
    int            last_hs_cyc = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_group(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        for (int j = 0; j < 4; j++) begin
            exp_q.push_back('{data: w[j], row: exp_row, last: (exp_row == RW'(ROWS - 1))});
            exp_row = (exp_row == RW'(ROWS - 1)) ? '0 : exp_row + RW'(1);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic [W-1:0] d,
                                input logic alt, input int idle);
        vec_t v;
        v.pe[0] = a; v.pe[1] = b; v.pe[2] = c; v.pe[3] = d;
        v.alt = alt; v.idle = idle;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        exp_row = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        for (t = 0; t < budget; t++) begin
            @(negedge clk);
            if (!busy) break;
        end
        nchk++;
        if (t == budget) begin
            nfail++;
            $display("FAIL idle_timeout actual=busy required=idle within %0d cycles", budget);
        end
        next_cycle();
    endtask

    // Scoreboard and stream-protocol monitor
    task automatic monitor();
        exp_t         e;
        logic         prev_stall = 1'b0;
        logic         fd_exp = 1'b0;
        logic [W-1:0] h_data = '0;
        logic [RW-1:0] h_row = '0;
        logic         h_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                fd_exp     = 1'b0;
            end else begin
                chk("frame_done", W'(frame_done), W'(fd_exp));
                if (frame_done) fd_count++;
                if (prev_stall) begin
                    chk("hold_valid", W'(out_valid), W'(1));
                    chk("hold_data", out_data, h_data);
                    chk("hold_row", W'(out_row), W'(h_row));
                    chk("hold_last", W'(out_last), W'(h_last));
                end
                fd_exp = 1'b0;
                if (out_valid && out_ready) begin
                    hs_count++;
                    last_hs_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        nchk++;
                        nfail++;
                        $display("FAIL unexpected_word actual=%0h row=%0d required=no word", out_data, out_row);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", out_data, e.data);
                        chk("word_row", W'(out_row), W'(e.row));
                        chk("word_last", W'(out_last), W'(e.last));
                        fd_exp = e.last;
                    end
                end
                prev_stall = out_valid && !out_ready;
                h_data = out_data;
                h_row  = out_row;
                h_last = out_last;
            end
        end
    endtask

    initial begin
        vec_t vecs [4];
        int   hs0;
        int   fd0;
        int   n0;

        vecs[0] = mk(64'd10, 64'd20, 64'd30, 64'd40, 1'b0, 6);
        vecs[1] = mk(64'd10, 64'd20, 64'd30, 64'd40, 1'b1, 10);
        vecs[2] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                     64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 6);
        vecs[3] = mk(64'hDEAD_BEEF_0123_4567, 64'hA5A5_A5A5_A5A5_A5A5,
                     64'h5A5A_5A5A_5A5A_5A5A, 64'h1, 1'b1, 10);

        rst = 1'b1; compute_done = 1'b0; out_ready = 1'b0;
        pe1 = '0; pe2 = '0; pe3 = '0; pe4 = '0;
        exp_row = '0;

        fork
            monitor();
        join_none

        // Reset state
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_row", W'(out_row), '0);
        chk("rst_out_last", W'(out_last), '0);
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_frame_done", W'(frame_done), '0);
        chk("rst_overflow", W'(overflow), '0);
        chk("rst_busy", W'(busy), '0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Single groups: latency, ordering, backpressure, idle time
        for (int i = 0; i < 4; i++) begin
            hs0 = hs_count;
            pe1 = vecs[i].pe[0]; pe2 = vecs[i].pe[1];
            pe3 = vecs[i].pe[2]; pe4 = vecs[i].pe[3];
            push_group(vecs[i].pe[0], vecs[i].pe[1], vecs[i].pe[2], vecs[i].pe[3]);
            for (int k = 0; k < 16; k++) begin
                compute_done = (k == 0);
                out_ready    = vecs[i].alt ? k[0] : 1'b1;
                @(negedge clk);
                if (k == 1) chk("latency_pre_valid", W'(out_valid), '0);
                if (k == 2) chk("latency_valid", W'(out_valid), W'(1));
                if (k == vecs[i].idle - 1) chk("busy_before_idle", W'(busy), W'(1));
                if (k == vecs[i].idle) chk("busy_at_idle", W'(busy), '0);
                next_cycle();
            end
            chk("vec_handshakes", W'(hs_count - hs0), W'(4));
        end

        // Overflow: five groups fit (one in the serializer, four queued)
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            pe1 = W'(i); pe2 = W'(i + 100); pe3 = W'(i + 200); pe4 = W'(i + 300);
            compute_done = 1'b1;
            if (i <= 5) push_group(W'(i), W'(i + 100), W'(i + 200), W'(i + 300));
            next_cycle();
            compute_done = 1'b0;
            @(negedge clk);
            chk("overflow_after_edge", W'(overflow), W'(i == 6));
            next_cycle();
        end
        hs0 = hs_count;
        out_ready = 1'b1;
        wait_idle(100);
        chk("overflow_drain_words", W'(hs_count - hs0), W'(20));
        chk("overflow_queue_empty", W'(exp_q.size()), '0);
        chk("overflow_sticky", W'(overflow), W'(1));

        // Level hold across reset release: exactly one capture
        compute_done = 1'b1;
        do_reset();
        hs0 = hs_count;
        pe1 = 64'h11; pe2 = 64'h22; pe3 = 64'h33; pe4 = 64'h44;
        push_group(64'h11, 64'h22, 64'h33, 64'h44);
        repeat (10) next_cycle();
        compute_done = 1'b0;
        wait_idle(40);
        chk("level_hold_words", W'(hs_count - hs0), W'(4));
        chk("overflow_cleared", W'(overflow), '0);

        // Full frame plus one group: no bubbles, single frame_done, row wrap
        do_reset();
        out_ready = 1'b1;
        hs0 = hs_count;
        fd0 = fd_count;
        n0  = cyc;
        for (int g = 0; g < 97; g++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) begin
                    pe1 = {32'(g), 32'd1}; pe2 = {32'(g), 32'd2};
                    pe3 = {32'(g), 32'd3}; pe4 = {32'(g), 32'd4};
                    push_group(pe1, pe2, pe3, pe4);
                end
                compute_done = (c < 2);
                next_cycle();
            end
        end
        compute_done = 1'b0;
        wait_idle(40);
        chk("frame_words", W'(hs_count - hs0), W'(388));
        chk("frame_last_hs_cycle", W'(last_hs_cyc - n0), W'(389));
        chk("frame_done_pulses", W'(fd_count - fd0), W'(1));

        // Reset during beat 2 with two groups queued
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pe1 = W'(64'hA0 + i); pe2 = W'(64'hB0 + i); pe3 = W'(64'hC0 + i); pe4 = W'(64'hD0 + i);
            if (i == 0) begin
                exp_q.push_back('{data: 64'hA0, row: 9'd0, last: 1'b0});
                exp_q.push_back('{data: 64'hB0, row: 9'd1, last: 1'b0});
            end
            compute_done = 1'b1;
            next_cycle();
            compute_done = 1'b0;
            next_cycle();
        end
        next_cycle();
        out_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_words_before", W'(exp_q.size()), '0);
        chk("midrst_beat2_data", out_data, 64'hC0);
        exp_q.delete();
        exp_row = '0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", W'(out_valid), '0);
        chk("midrst_busy", W'(busy), '0);
        chk("midrst_row", W'(out_row), '0);
        chk("midrst_data", out_data, '0);
        next_cycle();
        hs0 = hs_count;
        pe1 = 64'd77; pe2 = 64'd78; pe3 = 64'd79; pe4 = 64'd80;
        push_group(64'd77, 64'd78, 64'd79, 64'd80);
        compute_done = 1'b1;
        next_cycle();
        compute_done = 1'b0;
        wait_idle(40);
        chk("midrst_next_words", W'(hs_count - hs0), W'(4));
        chk("final_queue_empty", W'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
